// File: rtl/regfile_sequencer.sv
// Sequencer that drives a single-read/single-write-port register file:
// one operation per start pulse, operand reads one per cycle, then write-back.
module regfile_sequencer #(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [IMM_W-1:0] imm,
  input  logic [W-1:0]     rf_data_out,
  output logic [2:0]       rf_readnum,
  output logic [2:0]       rf_writenum,
  output logic             rf_write,
  output logic [W-1:0]     rf_data_in,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             z,
  output logic             n,
  output logic             v
);

  typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, DONE} state_t;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  state_t         state;
  logic [1:0]     op;
  logic [2:0]     rm_q;
  logic [W-1:0]   a;
  logic [W-1:0]   b;

  function automatic logic [W-1:0] sext(input logic [IMM_W-1:0] i);
    return {{(W-IMM_W){i[IMM_W-1]}}, i};
  endfunction

  function automatic logic [W-1:0] alu(input logic [1:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    case (o)
      OP_ADD:  return x + y;
      OP_AND:  return x & y;
      OP_MVN:  return ~y;
      default: return {W{1'b0}};
    endcase
  endfunction

  function automatic logic add_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Control outputs are registered one state ahead, so each one is valid for the
  // whole cycle of the state that owns it and asynchronous reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= 2'b00;
      rm_q        <= 3'd0;
      a           <= {W{1'b0}};
      b           <= {W{1'b0}};
      rf_readnum  <= 3'd0;
      rf_writenum <= 3'd0;
      rf_write    <= 1'b0;
      rf_data_in  <= {W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= {W{1'b0}};
      z           <= 1'b0;
      n           <= 1'b0;
      v           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op          <= opcode;
            rm_q        <= rm;
            rf_writenum <= rd;
            busy        <= 1'b1;
            case (opcode)
              OP_MOVI: begin
                state      <= WRITE;
                rf_write   <= 1'b1;
                rf_data_in <= sext(imm);
              end
              OP_MVN: begin
                state      <= READ_B;
                rf_readnum <= rm;
              end
              default: begin
                state      <= READ_A;
                rf_readnum <= rn;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        READ_A: begin
          a          <= rf_data_out;
          rf_readnum <= rm_q;
          state      <= READ_B;
        end
        READ_B: begin
          // Result is formed here from the live second operand so WRITE can drive it.
          b          <= rf_data_out;
          rf_readnum <= 3'd0;
          rf_write   <= 1'b1;
          rf_data_in <= alu(op, a, rf_data_out);
          state      <= WRITE;
        end
        WRITE: begin
          rf_write   <= 1'b0;
          rf_data_in <= {W{1'b0}};
          result     <= rf_data_in;
          z          <= (rf_data_in == {W{1'b0}});
          n          <= rf_data_in[W-1];
          v          <= (op == OP_ADD) && add_ovf(a, b, rf_data_in);
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rf_readnum <= 3'd0;
          rf_write   <= 1'b0;
          rf_data_in <= {W{1'b0}};
          done       <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file plus a scoreboard
// of expected write-backs computed from the bench's own register image.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [2:0]  rd = 3'd0, rn = 3'd0, rm = 3'd0;
  logic [7:0]  imm = 8'h00;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write, busy, done, z, n, v;
  logic [15:0] rf_data_in, result;

  int vectors = 0;
  int miscompares = 0;

  regfile_sequencer #(.W(16), .IMM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .rd(rd), .rn(rn),
    .rm(rm), .imm(imm), .rf_data_out(rf_data_out), .rf_readnum(rf_readnum),
    .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
    .busy(busy), .done(done), .result(result), .z(z), .n(n), .v(v)
  );

  always #5 clk = ~clk;

  // Behavioural 8x16 register file with a bench-side preload port
  logic [15:0] rf [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = 3'd0;
  logic [15:0] pl_data = 16'h0000;
  assign rf_data_out = rf[rf_readnum];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
  end

  int done_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rf_write) wr_cnt++;
  end

  typedef struct packed {
    logic [2:0]  num;
    logic [15:0] data;
    logic        z, n, v;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mrf [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; mrf[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives a one-cycle start and pushes the expected write-back; returns in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] im);
    exp_t e;
    logic [15:0] a, b, f;
    a = mrf[s1]; b = mrf[s2];
    case (op)
      2'b00:   f = {{8{im[7]}}, im};
      2'b01:   f = a + b;
      2'b10:   f = a & b;
      default: f = ~b;
    endcase
    e.num = d; e.data = f; e.z = (f == 16'h0000); e.n = f[15];
    e.v = (op == 2'b01) && (a[15] == b[15]) && (f[15] != a[15]);
    q.push_back(e);
    opcode = op; rd = d; rn = s1; rm = s2; imm = im; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_wb(output int cnt);
    cnt = 0;
    while (rf_write !== 1'b1 && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({busy, done, rf_write, rf_readnum, rf_writenum, rf_data_in, result, z, n, v} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, rf_write, rf_readnum, rf_writenum, rf_data_in, result, z, n, v});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_movi();
    int lat; exp_t e;
    issue(2'b00, 3'd3, 3'd0, 3'd0, 8'hF0);
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if (lat !== 0) begin miscompares++; $display("FAIL movi_latency: got %0d expected 0", lat); end
    vectors++;
    if ({rf_writenum, rf_data_in} !== {3'd3, 16'hFFF0} || e.data !== 16'hFFF0) begin
      miscompares++;
      $display("FAIL movi_wb: got %h/%h expected 3/fff0", rf_writenum, rf_data_in);
    end
    @(negedge clk);
    vectors++;
    if ({done, result, z, n, v} !== {1'b1, e.data, e.z, e.n, e.v}) begin
      miscompares++;
      $display("FAIL movi_done: got %h expected %h", {done, result, z, n, v}, {1'b1, e.data, e.z, e.n, e.v});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL movi_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_add_overflow();
    int lat; exp_t e;
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    issue(2'b01, 3'd4, 3'd1, 3'd2, 8'h00);
    vectors++;
    if ({busy, rf_readnum} !== {1'b1, 3'd1}) begin
      miscompares++; $display("FAIL add_read_a: got %h expected 9", {busy, rf_readnum});
    end
    @(negedge clk);
    vectors++;
    if (rf_readnum !== 3'd2) begin miscompares++; $display("FAIL add_read_b: got %0d expected 2", rf_readnum); end
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d expected 1", lat); end
    vectors++;
    if ({rf_writenum, rf_data_in} !== {e.num, e.data}) begin
      miscompares++; $display("FAIL add_wb: got %h/%h expected %h/%h", rf_writenum, rf_data_in, e.num, e.data);
    end
    @(negedge clk);
    vectors++;
    if ({done, result, z, n, v} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL add_flags: got %h expected %h", {done, result, z, n, v}, {1'b1, 16'h8000, 3'b011});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
    vectors++;
    if (rf[4] !== mrf[4]) begin miscompares++; $display("FAIL add_r4: got %h expected %h", rf[4], mrf[4]); end
  endtask

  task automatic test_and_mvn();
    int lat; exp_t e;
    preload(3'd5, 16'h00FF);
    issue(2'b10, 3'd5, 3'd5, 3'd5, 8'h00);
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if ({lat[3:0], rf_writenum, rf_data_in} !== {4'd2, e.num, e.data}) begin
      miscompares++; $display("FAIL and_self_wb: got %0d/%h/%h expected 2/%h/%h", lat, rf_writenum, rf_data_in, e.num, e.data);
    end
    @(negedge clk);
    mrf[e.num] = e.data;
    @(negedge clk);
    issue(2'b11, 3'd6, 3'd0, 3'd5, 8'h00);
    vectors++;
    if (rf_readnum !== 3'd5) begin miscompares++; $display("FAIL mvn_read: got %0d expected 5", rf_readnum); end
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if ({lat[3:0], rf_writenum, rf_data_in} !== {4'd1, e.num, e.data}) begin
      miscompares++; $display("FAIL mvn_wb: got %0d/%h/%h expected 1/%h/%h", lat, rf_writenum, rf_data_in, e.num, e.data);
    end
    @(negedge clk);
    vectors++;
    if ({done, result, z, n, v} !== {1'b1, 16'hFF00, 1'b0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL mvn_flags: got %h expected %h", {done, result, z, n, v}, {1'b1, 16'hFF00, 3'b010});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
    vectors++;
    if ({rf[5], rf[6]} !== {mrf[5], mrf[6]} || mrf[5] !== 16'h00FF) begin
      miscompares++; $display("FAIL and_mvn_regs: got %h %h expected %h %h", rf[5], rf[6], mrf[5], mrf[6]);
    end
  endtask

  task automatic test_start_ignored();
    int d0, w0; exp_t e;
    logic [18:0] wbv = 19'd0;
    logic [19:0] flv = 20'd0;
    preload(3'd0, 16'h0F0F);
    preload(3'd7, 16'hF0F0);
    d0 = done_cnt; w0 = wr_cnt;
    issue(2'b10, 3'd0, 3'd0, 3'd7, 8'h00);
    opcode = 2'b00; rd = 3'd1; imm = 8'h55; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (rf_write) wbv = {rf_writenum, rf_data_in};
      if (done) flv = {1'b1, result, z, n, v};
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    e = q.pop_front();
    mrf[e.num] = e.data;
    vectors++;
    if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 1) begin
      miscompares++; $display("FAIL ignore_counts: got done=%0d wr=%0d expected 1/1", done_cnt - d0, wr_cnt - w0);
    end
    vectors++;
    if ({wbv, flv} !== {e.num, e.data, 1'b1, e.data, 1'b1, e.n, e.v}) begin
      miscompares++; $display("FAIL ignore_result: got %h %h expected %h", wbv, flv, e.data);
    end
    vectors++;
    if ({rf[0], rf[1]} !== {16'h0000, mrf[1]}) begin
      miscompares++; $display("FAIL ignore_regs: got %h %h expected 0000 %h", rf[0], rf[1], mrf[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; exp_t e;
    issue(2'b00, 3'd2, 3'd0, 3'd0, 8'h81);
    e = q.pop_front();
    vectors++;
    if ({rf_write, rf_writenum, rf_data_in} !== {1'b1, e.num, e.data}) begin
      miscompares++; $display("FAIL b2b_first_wb: got %h expected %h", {rf_write, rf_writenum, rf_data_in}, {1'b1, e.num, e.data});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
    vectors++;
    if ({done, result} !== {1'b1, 16'hFF81}) begin
      miscompares++; $display("FAIL b2b_first_done: got %h expected 1ff81", {done, result});
    end
    @(negedge clk);
    issue(2'b00, 3'd1, 3'd0, 3'd0, 8'h00);
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if ({lat[3:0], rf_writenum, rf_data_in} !== {4'd0, e.num, e.data}) begin
      miscompares++; $display("FAIL b2b_second_wb: got %0d/%h/%h expected 0/%h/%h", lat, rf_writenum, rf_data_in, e.num, e.data);
    end
    @(negedge clk);
    vectors++;
    if ({done, result, z, n, v} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL b2b_zero_flag: got %h expected %h", {done, result, z, n, v}, {1'b1, 16'h0000, 3'b100});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; exp_t e;
    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h1111);
    preload(3'd3, 16'hAAAA);
    issue(2'b01, 3'd3, 3'd1, 3'd2, 8'h00);
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if ({lat[3:0], rf_write} !== {4'd2, 1'b1}) begin
      miscompares++; $display("FAIL abort_in_write: got %0d/%b expected 2/1", lat, rf_write);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, rf_write, rf_readnum, rf_writenum, rf_data_in, result, z, n, v} !== 44'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h expected 0",
               {busy, done, rf_write, rf_readnum, rf_writenum, rf_data_in, result, z, n, v});
    end
    @(negedge clk);
    vectors++;
    if (rf[3] !== mrf[3] || e.data === mrf[3]) begin
      miscompares++; $display("FAIL abort_r3: got %h expected %h", rf[3], mrf[3]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 3'd3, 3'd0, 3'd0, 8'h7F);
    wait_wb(lat);
    e = q.pop_front();
    vectors++;
    if ({lat[3:0], rf_writenum, rf_data_in} !== {4'd0, 3'd3, 16'h007F}) begin
      miscompares++; $display("FAIL post_reset_wb: got %0d/%h/%h expected 0/3/007f", lat, rf_writenum, rf_data_in);
    end
    @(negedge clk);
    vectors++;
    if ({done, result, z, n, v} !== {1'b1, e.data, e.z, e.n, e.v}) begin
      miscompares++; $display("FAIL post_reset_done: got %h expected %h", {done, result, z, n, v}, {1'b1, e.data, e.z, e.n, e.v});
    end
    mrf[e.num] = e.data;
    @(negedge clk);
    vectors++;
    if (rf[3] !== mrf[3]) begin miscompares++; $display("FAIL post_reset_r3: got %h expected %h", rf[3], mrf[3]); end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_add_overflow();
    test_and_mvn();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
